// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit counters, trained by resolved execute results.
// Optional performance counters are enabled by defining BPU_PERF_CNT_EN.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [7:0]  upd_jump_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_miss_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] uncond_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             upd_accept;
    logic             uncond_new;
    logic             wr_en;
    logic [1:0]       ctr_new;
    logic [31:0]      target_new;

    // Word-aligned PCs: the two low bits never reach the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = if_pc[31:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
    assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;

    assign up_idx     = upd_pc[IDX_W+1:2];
    assign up_tag     = upd_pc[31:IDX_W+2];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign upd_accept = upd_valid && (|upd_jump_type);
    assign uncond_new = |upd_jump_type[1:0];
    assign wr_en      = upd_accept && (up_hit || upd_taken);
    assign target_new = (up_hit && !upd_taken) ? target_q[up_idx] : upd_target;

    // NOTE: every variable written here gets a default first so no latch can be inferred.
    always_comb begin
        ctr_new = 2'b10;
        if (up_hit) begin
            if (uncond_new) begin
                ctr_new = 2'b11;
            end else if (upd_taken) begin
                ctr_new = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
            end else begin
                ctr_new = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
            end
        end else if (uncond_new) begin
            ctr_new = 2'b11;
        end
    end

    // NOTE: the tables are reset entry by entry; a stale valid bit after reset would fire false predictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            uncond_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= 1'b1;
            uncond_q[up_idx] <= uncond_new;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= target_new;
            ctr_q[up_idx]    <= ctr_new;
        end
    end

    assign mispredict = upd_accept &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] miss_cnt_q;

    // Counting continues through a flush: the instruction still resolved even if training is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (upd_accept) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) miss_cnt_q   <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_branch_cnt = branch_cnt_q;
    assign perf_miss_cnt   = miss_cnt_q;
`else
    assign perf_branch_cnt = 32'd0;
    assign perf_miss_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, index = pc[5:2]).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_jump_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_miss_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] JAL  = 8'h01;
    localparam logic [7:0] JALR = 8'h02;
    localparam logic [7:0] BEQ  = 8'h04;
    localparam logic [7:0] BNE  = 8'h08;
    localparam logic [7:0] BGE  = 8'h20;

`ifdef BPU_PERF_CNT_EN
    localparam logic [31:0] EXP_BRANCHES = 32'd11;
    localparam logic [31:0] EXP_MISSES   = 32'd8;
`else
    localparam logic [31:0] EXP_BRANCHES = 32'd0;
    localparam logic [31:0] EXP_MISSES   = 32'd0;
`endif

    branch_predictor #(.ENTRIES(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_jump_type   (upd_jump_type),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .perf_branch_cnt (perf_branch_cnt),
        .perf_miss_cnt   (perf_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [7:0] jt, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_jump_type   = jt;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic idle();
        upd_valid     = 1'b0;
        upd_jump_type = 8'h00;
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    task automatic resolve(input string tag, input logic exp_mp, input logic [31:0] exp_rpc);
        #1;
        check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
        check({tag, "_redirect"}, redirect_pc, exp_rpc);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        if_pc = 32'h8000_0000;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;
        idle();
        #12;
        lookup("reset", 32'h8000_0000, 1'b0, 32'h8000_0004);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        check("reset_perf_branch", perf_branch_cnt, 32'd0);
        check("reset_perf_miss", perf_miss_cnt, 32'd0);
        rst_n = 1'b1;
        tick();

        // beq allocation; same-cycle lookup sees pre-update contents
        upd(BEQ, 32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0014);
        resolve("beq_alloc", 1'b1, 32'h8000_0040);
        lookup("no_bypass", 32'h8000_0010, 1'b0, 32'h8000_0014);
        tick();
        idle();
        lookup("beq_trained", 32'h8000_0010, 1'b1, 32'h8000_0040);

        // two not-taken resolutions: ctr 2 -> 1 -> 0
        upd(BEQ, 32'h8000_0010, 1'b0, 32'h8000_0040, 1'b1, 32'h8000_0040);
        resolve("beq_nt1", 1'b1, 32'h8000_0014);
        tick();
        idle();
        lookup("beq_ctr1", 32'h8000_0010, 1'b0, 32'h8000_0014);
        upd(BEQ, 32'h8000_0010, 1'b0, 32'h8000_0040, 1'b0, 32'h8000_0014);
        resolve("beq_nt2", 1'b0, 32'h8000_0014);
        tick();
        idle();
        lookup("beq_ctr0", 32'h8000_0010, 1'b0, 32'h8000_0014);

        // from ctr 0 one taken leaves it weakly not-taken, a second makes it predict
        upd(BEQ, 32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0014);
        resolve("beq_t1", 1'b1, 32'h8000_0040);
        tick();
        idle();
        lookup("beq_ctr_up1", 32'h8000_0010, 1'b0, 32'h8000_0014);
        upd(BEQ, 32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0014);
        tick();
        idle();
        lookup("beq_ctr_up2", 32'h8000_0010, 1'b1, 32'h8000_0040);

        // jalr with changing target
        upd(JALR, 32'h8000_0100, 1'b1, 32'h8000_1000, 1'b0, 32'h8000_0104);
        resolve("jalr_first", 1'b1, 32'h8000_1000);
        tick();
        idle();
        lookup("jalr_t1", 32'h8000_0100, 1'b1, 32'h8000_1000);
        upd(JALR, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_1000);
        resolve("jalr_target_miss", 1'b1, 32'h8000_2000);
        tick();
        idle();
        lookup("jalr_t2", 32'h8000_0100, 1'b1, 32'h8000_2000);
        upd(JALR, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b1, 32'h8000_2000);
        resolve("jalr_correct", 1'b0, 32'h8000_2000);
        tick();
        idle();

        // upd_valid with empty jump type is ignored entirely
        upd(8'h00, 32'h8000_0204, 1'b1, 32'h8000_0300, 1'b0, 32'h8000_0208);
        resolve("jt0_ignored", 1'b0, 32'h8000_0300);
        tick();
        idle();
        lookup("jt0_no_alloc", 32'h8000_0204, 1'b0, 32'h8000_0208);

        // aliasing: jal at 0x50 evicts the beq at 0x10 (both index 4)
        upd(JAL, 32'h8000_0050, 1'b1, 32'h8000_0800, 1'b0, 32'h8000_0054);
        resolve("jal_alias", 1'b1, 32'h8000_0800);
        tick();
        idle();
        lookup("alias_evicted", 32'h8000_0010, 1'b0, 32'h8000_0014);
        lookup("alias_jal_hit", 32'h8000_0050, 1'b1, 32'h8000_0800);

        // not-taken miss must not allocate
        upd(BNE, 32'h8000_0020, 1'b0, 32'h8000_0700, 1'b0, 32'h8000_0024);
        resolve("bne_nt_miss", 1'b0, 32'h8000_0024);
        tick();
        idle();
        lookup("bne_no_alloc", 32'h8000_0020, 1'b0, 32'h8000_0024);

        // flush with simultaneous update: update dropped, mispredict still reported
        flush = 1'b1;
        upd(BGE, 32'h8000_0030, 1'b1, 32'h8000_0900, 1'b0, 32'h8000_0034);
        resolve("flush_upd", 1'b1, 32'h8000_0900);
        tick();
        flush = 1'b0;
        idle();
        lookup("flush_jalr", 32'h8000_0100, 1'b0, 32'h8000_0104);
        lookup("flush_jal", 32'h8000_0050, 1'b0, 32'h8000_0054);
        lookup("flush_bge_dropped", 32'h8000_0030, 1'b0, 32'h8000_0034);
        check("perf_branch", perf_branch_cnt, EXP_BRANCHES);
        check("perf_miss", perf_miss_cnt, EXP_MISSES);

        // retrain, then assert reset between edges: tables clear immediately
        upd(JALR, 32'h8000_0100, 1'b1, 32'h8000_3000, 1'b0, 32'h8000_0104);
        tick();
        idle();
        lookup("retrain", 32'h8000_0100, 1'b1, 32'h8000_3000);
        rst_n = 1'b0;
        lookup("midreset", 32'h8000_0100, 1'b0, 32'h8000_0104);
        check("midreset_perf_branch", perf_branch_cnt, 32'd0);
        check("midreset_perf_miss", perf_miss_cnt, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
